// File: rtl/pwm_ramp_sequencer.sv
// pwm_ramp_sequencer
//
// Host-side controller for the PWM generator's 12-bit configuration write bus.
// Takes one command (period, target duty %, step %, step interval). It writes the
// period once, when it differs from the last period written, and then steps the
// duty toward the target. Each duty write is spaced cmd_interval+2 cycles from the
// previous one. This block is the only writer of the generator bus.
//
// Ports:
//   clk           system clock
//   rst_n         synchronous reset, active HIGH (name kept from the existing codebase)
//   cmd_valid     command present
//   cmd_ready     command can be accepted (idle and not in reset)
//   cmd_period    PWM period in clk cycles
//   cmd_duty      target duty in percent, clamped to DUTY_MAX
//   cmd_step      duty increment per step in percent; 0 is treated as 1
//   cmd_interval  extra wait cycles between steps
//   abort         drop the current sequence; no done pulse is produced
//   pwm_in        generator write data
//   pwm_sel       1 = period write, 0 = duty write
//   pwm_wr_en     generator write strobe, 1-cycle pulses
//   cur_duty      last duty value written
//   busy          sequence in progress
//   done          1-cycle pulse when the target is reached
module pwm_ramp_sequencer #(
  parameter int unsigned INT_W    = 16,
  parameter int unsigned DUTY_MAX = 100
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [11:0]      cmd_period,
  input  logic [6:0]       cmd_duty,
  input  logic [6:0]       cmd_step,
  input  logic [INT_W-1:0] cmd_interval,
  input  logic             abort,
  output logic [11:0]      pwm_in,
  output logic             pwm_sel,
  output logic             pwm_wr_en,
  output logic [6:0]       cur_duty,
  output logic             busy,
  output logic             done
);

  localparam logic [6:0] DutyMax = 7'(DUTY_MAX);

  typedef enum logic [2:0] {
    StIdle,
    StWrPeriod,
    StWait,
    StStep,
    StDone
  } state_e;

  state_e           state_q;
  logic [11:0]      shadow_q;
  logic [6:0]       target_q;
  logic [6:0]       step_q;
  logic [6:0]       duty_q;
  logic [INT_W-1:0] interval_q;
  logic [INT_W-1:0] count_q;
  logic [11:0]      pwm_in_q;
  logic             pwm_sel_q;
  logic             pwm_wr_en_q;
  logic             done_q;

  logic [6:0] acc_target;
  logic [6:0] acc_step;
  logic [6:0] nxt_duty;
  logic [7:0] cur_w, tgt_w, stp_w, sum_w, gap_w;

  assign acc_target = (cmd_duty > DutyMax) ? DutyMax : cmd_duty;
  assign acc_step   = (cmd_step == 7'd0) ? 7'd1 : cmd_step;

  // Next duty value: move by one step toward the target, saturating on it.
  // The arithmetic is widened to 8 bits so that cur+step cannot wrap.
  always_comb begin
    cur_w    = {1'b0, duty_q};
    tgt_w    = {1'b0, target_q};
    stp_w    = {1'b0, step_q};
    sum_w    = cur_w + stp_w;
    gap_w    = cur_w - tgt_w;
    nxt_duty = target_q;
    if (cur_w < tgt_w) begin
      if (sum_w < tgt_w) nxt_duty = sum_w[6:0];
    end else if (gap_w > stp_w) begin
      nxt_duty = duty_q - step_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      state_q     <= StIdle;
      shadow_q    <= 12'd0;
      target_q    <= 7'd0;
      step_q      <= 7'd1;
      duty_q      <= 7'd0;
      interval_q  <= '0;
      count_q     <= '0;
      pwm_in_q    <= 12'd0;
      pwm_sel_q   <= 1'b0;
      pwm_wr_en_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      // Strobe and done are single-cycle pulses by default.
      pwm_wr_en_q <= 1'b0;
      done_q      <= 1'b0;
      if (abort && state_q != StIdle) begin
        state_q <= StIdle;
      end else begin
        unique case (state_q)
          StIdle: begin
            if (cmd_valid) begin
              target_q   <= acc_target;
              step_q     <= acc_step;
              interval_q <= cmd_interval;
              if (cmd_period != shadow_q) begin
                // Present the period write and record it as written at once.
                state_q     <= StWrPeriod;
                shadow_q    <= cmd_period;
                pwm_in_q    <= cmd_period;
                pwm_sel_q   <= 1'b1;
                pwm_wr_en_q <= 1'b1;
              end else if (duty_q != acc_target) begin
                state_q <= StWait;
                count_q <= cmd_interval;
              end else begin
                state_q <= StDone;
                done_q  <= 1'b1;
              end
            end
          end
          StWrPeriod: begin
            if (duty_q != target_q) begin
              state_q <= StWait;
              count_q <= interval_q;
            end else begin
              state_q <= StDone;
              done_q  <= 1'b1;
            end
          end
          StWait: begin
            if (count_q == '0) begin
              state_q     <= StStep;
              duty_q      <= nxt_duty;
              pwm_in_q    <= {5'b0, nxt_duty};
              pwm_sel_q   <= 1'b0;
              pwm_wr_en_q <= 1'b1;
            end else begin
              count_q <= count_q - 1'b1;
            end
          end
          StStep: begin
            if (duty_q == target_q) begin
              state_q <= StDone;
              done_q  <= 1'b1;
            end else begin
              state_q <= StWait;
              count_q <= interval_q;
            end
          end
          StDone: begin
            state_q <= StIdle;
          end
          default: begin
            state_q <= StIdle;
          end
        endcase
      end
    end
  end

  assign cmd_ready = (state_q == StIdle) && !rst_n;
  assign busy      = (state_q != StIdle);
  assign pwm_in    = pwm_in_q;
  assign pwm_sel   = pwm_sel_q;
  assign pwm_wr_en = pwm_wr_en_q;
  assign cur_duty  = duty_q;
  assign done      = done_q;

endmodule

// File: tb/tb_pwm_ramp_sequencer.sv
// Self-checking bench for pwm_ramp_sequencer. For each command a reference model
// computes the list of writes (cycle, select, data) and the done cycle from the
// ramp rules. The bench then records what the DUT puts on the bus and compares
// the two.
module tb_pwm_ramp_sequencer;

  localparam int DutyMax = 100;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [11:0] cmd_period;
  logic [6:0]  cmd_duty;
  logic [6:0]  cmd_step;
  logic [15:0] cmd_interval;
  logic        abort;
  logic [11:0] pwm_in;
  logic        pwm_sel;
  logic        pwm_wr_en;
  logic [6:0]  cur_duty;
  logic        busy;
  logic        done;

  pwm_ramp_sequencer #(
    .INT_W    (16),
    .DUTY_MAX (DutyMax)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_period   (cmd_period),
    .cmd_duty     (cmd_duty),
    .cmd_step     (cmd_step),
    .cmd_interval (cmd_interval),
    .abort        (abort),
    .pwm_in       (pwm_in),
    .pwm_sel      (pwm_sel),
    .pwm_wr_en    (pwm_wr_en),
    .cur_duty     (cur_duty),
    .busy         (busy),
    .done         (done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int cyc;
    int sel;
    int data;
  } wr_t;

  wr_t exp_q[$];
  wr_t act_q[$];

  int n_checks = 0;
  int n_errors = 0;

  // Model state: last duty written and last period written.
  int m_cur = 0;
  int m_shadow = 0;

  task automatic check_eq(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Issue one command and check everything the DUT writes in response.
  // cut_k > 0 cuts the ramp in the cycle after the cut_k-th duty write, using
  // abort (cut_rst=0) or reset (cut_rst=1). abort_acc raises abort in the accept cycle.
  task automatic run_cmd(input logic [11:0] per, input logic [6:0] duty, input logic [6:0] stp,
                         input int intv, input int cut_k, input bit cut_rst,
                         input bit abort_acc);
    wr_t w;
    int  acc, stop, exp_done, cut_cyc, done_n, done_cyc, cur, tgt, st, t;
    int  duty_cyc[$];
    exp_q.delete();
    act_q.delete();
    @(negedge clk);
    check_eq("ready_pre", int'(cmd_ready), 1);
    acc          = cyc;
    cmd_period   = per;
    cmd_duty     = duty;
    cmd_step     = stp;
    cmd_interval = 16'(intv);
    cmd_valid    = 1'b1;
    abort        = abort_acc;

    // Reference model.
    tgt = (int'(duty) > DutyMax) ? DutyMax : int'(duty);
    st  = (stp == 7'd0) ? 1 : int'(stp);
    cur = m_cur;
    t   = acc;
    if (int'(per) != m_shadow) begin
      t++;
      w.cyc = t; w.sel = 1; w.data = int'(per);
      exp_q.push_back(w);
      m_shadow = int'(per);
    end
    while (cur != tgt) begin
      t += intv + 2;
      if (cur < tgt) cur = (cur + st > tgt) ? tgt : cur + st;
      else           cur = (cur - st < tgt) ? tgt : cur - st;
      w.cyc = t; w.sel = 0; w.data = cur;
      exp_q.push_back(w);
      duty_cyc.push_back(t);
    end
    exp_done = t + 1;
    stop     = t + 1;
    cut_cyc  = -1;
    if (cut_k > 0 && cut_k < duty_cyc.size()) begin
      cut_cyc  = duty_cyc[cut_k-1] + 1;
      stop     = cut_cyc;
      exp_done = -1;
      while (exp_q.size() > 0 && exp_q[$].cyc > cut_cyc) void'(exp_q.pop_back());
      if (cut_rst) begin
        m_cur    = 0;
        m_shadow = 0;
      end else begin
        m_cur = exp_q[$].data;
      end
    end else begin
      m_cur = cur;
    end

    done_n   = 0;
    done_cyc = -1;
    for (int c = acc + 1; c <= stop + 2; c++) begin
      @(negedge clk);
      if (pwm_wr_en) begin
        w.cyc = cyc; w.sel = int'(pwm_sel); w.data = int'(pwm_in);
        act_q.push_back(w);
      end
      if (done) begin
        done_n++;
        if (done_cyc < 0) done_cyc = cyc;
      end
      check_eq("busy", int'(busy), int'(cyc > acc && cyc <= stop));
      abort = (cyc == cut_cyc) && !cut_rst;
      rst_n = (cyc == cut_cyc) && cut_rst;
      // Commands offered while busy must be ignored.
      if (cyc < stop && $urandom_range(0, 3) == 0) begin
        cmd_valid    = 1'b1;
        cmd_period   = 12'($urandom);
        cmd_duty     = 7'($urandom);
        cmd_step     = 7'($urandom);
        cmd_interval = 16'($urandom_range(0, 3));
      end else begin
        cmd_valid = 1'b0;
      end
    end

    check_eq("n_writes", act_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < act_q.size(); i++) begin
      check_eq("wr_cycle", act_q[i].cyc - acc, exp_q[i].cyc - acc);
      check_eq("wr_sel", act_q[i].sel, exp_q[i].sel);
      check_eq("wr_data", act_q[i].data, exp_q[i].data);
    end
    check_eq("done_count", done_n, int'(exp_done >= 0));
    if (exp_done >= 0 && done_n > 0) check_eq("done_cycle", done_cyc - acc, exp_done - acc);
    check_eq("cur_duty", int'(cur_duty), m_cur);
    check_eq("ready_post", int'(cmd_ready), 1);
  endtask

  initial begin
    repeat (90000) @(posedge clk);
    $display("FAIL watchdog: got cycle %0d expected finish before it", cyc);
    $fatal(1);
  end

  initial begin
    int per, k;
    rst_n        = 1'b1;
    cmd_valid    = 1'b0;
    cmd_period   = 12'd0;
    cmd_duty     = 7'd0;
    cmd_step     = 7'd0;
    cmd_interval = 16'd0;
    abort        = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("rst_pwm_in", int'(pwm_in), 0);
    check_eq("rst_pwm_sel", int'(pwm_sel), 0);
    check_eq("rst_wr_en", int'(pwm_wr_en), 0);
    check_eq("rst_cur_duty", int'(cur_duty), 0);
    check_eq("rst_busy", int'(busy), 0);
    check_eq("rst_done", int'(done), 0);
    check_eq("rst_ready", int'(cmd_ready), 0);
    rst_n = 1'b0;
    @(negedge clk);
    check_eq("rel_ready", int'(cmd_ready), 1);
    check_eq("rel_busy", int'(busy), 0);

    run_cmd(12'd1000, 7'd50, 7'd10, 3, 0, 1'b0, 1'b0);   // period + 10..50
    run_cmd(12'd1000, 7'd25, 7'd10, 0, 0, 1'b0, 1'b0);   // 40,30,25
    run_cmd(12'd1000, 7'd98, 7'd73, 0, 0, 1'b0, 1'b0);   // 98
    run_cmd(12'd1000, 7'd120, 7'd0, 0, 0, 1'b0, 1'b0);   // 99,100 clamped
    run_cmd(12'd2000, 7'd50, 7'd10, 3, 2, 1'b1, 1'b0);   // reset mid-ramp
    run_cmd(12'd1000, 7'd50, 7'd10, 3, 2, 1'b0, 1'b1);   // abort after 20
    run_cmd(12'd1000, 7'd20, 7'd7, 2, 0, 1'b0, 1'b0);    // no-op
    run_cmd(12'd1000, 7'd60, 7'd15, 1, 0, 1'b0, 1'b0);
    run_cmd(12'd1000, 7'd60, 7'd15, 1, 0, 1'b0, 1'b0);   // identical repeat: no writes

    for (int n = 0; n < 25; n++) begin
      per = ($urandom_range(0, 1) == 0) ? m_shadow : int'($urandom_range(1, 4095));
      k   = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0;
      run_cmd(12'(per), 7'($urandom),
              ($urandom_range(0, 1) == 0) ? 7'($urandom_range(0, 5)) : 7'($urandom),
              int'($urandom_range(0, 4)), k, 1'($urandom_range(0, 1)),
              1'($urandom_range(0, 1)));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
